// File: rtl/lpif_asym2_pkg.sv
// rtl/lpif_asym2_pkg.sv - word/payload layout, aligner states and window test for the asym2 slave rx aligner
package lpif_asym2_pkg;
  localparam int MRK_BIT = 79;
  localparam int STB_BIT = 0;
  localparam int PLD_LSB = 1;
  localparam int PLD_W   = 77;
  localparam int WORD_W  = 80;

  typedef enum logic [1:0] {
    OFFLINE = 2'b00,
    HUNT    = 2'b01,
    CHECK   = 2'b10,
    LOCKED  = 2'b11
  } align_state_e;

  // Declared MSB first so that state lands in payload bits [3:0].
  typedef struct packed {
    logic        valid;
    logic        crc_valid;
    logic [3:0]  crc;
    logic        dvalid;
    logic [63:0] data;
    logic [1:0]  protid;
    logic [3:0]  state;
  } payload_t;

  function automatic logic window_good(input logic [WORD_W-1:0] first,
                                       input logic [WORD_W-1:0] second);
    return first[MRK_BIT] && !second[MRK_BIT] && first[STB_BIT];
  endfunction
endpackage

// File: rtl/lpif_txrx_x4_asym2_half_slave_rx_align_if.sv
// rtl/lpif_txrx_x4_asym2_half_slave_rx_align_if.sv - phy input and upstream/status outputs of the rx aligner
interface lpif_txrx_x4_asym2_half_slave_rx_align_if;
  logic         rx_online;
  logic [159:0] rx_phy0;
  logic [7:0]   ustrm_state;
  logic [3:0]   ustrm_protid;
  logic [127:0] ustrm_data;
  logic [1:0]   ustrm_dvalid;
  logic [7:0]   ustrm_crc;
  logic [1:0]   ustrm_crc_valid;
  logic [1:0]   ustrm_valid;
  logic         rx_align_locked;
  logic         rx_align_phase;
  logic [15:0]  rx_align_err_cnt;
  logic [31:0]  rx_upstream_debug_status;

  modport slave (
    input  rx_online, rx_phy0,
    output ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid, ustrm_crc,
           ustrm_crc_valid, ustrm_valid, rx_align_locked, rx_align_phase,
           rx_align_err_cnt, rx_upstream_debug_status
  );

  modport master (
    output rx_online, rx_phy0,
    input  ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid, ustrm_crc,
           ustrm_crc_valid, ustrm_valid, rx_align_locked, rx_align_phase,
           rx_align_err_cnt, rx_upstream_debug_status
  );
endinterface

// File: rtl/lpif_asym2_payload_unpack.sv
// rtl/lpif_asym2_payload_unpack.sv - splits one 77-bit payload into the LPIF upstream fields of one beat
module lpif_asym2_payload_unpack
  import lpif_asym2_pkg::*;
(
  input  logic [PLD_W-1:0] payload,
  output logic [3:0]       state,
  output logic [1:0]       protid,
  output logic [63:0]      data,
  output logic             dvalid,
  output logic [3:0]       crc,
  output logic             crc_valid,
  output logic             valid
);
  payload_t p;

  assign p         = payload;
  assign state     = p.state;
  assign protid    = p.protid;
  assign data      = p.data;
  assign dvalid    = p.dvalid;
  assign crc       = p.crc;
  assign crc_valid = p.crc_valid;
  assign valid     = p.valid;
endmodule

// File: rtl/lpif_txrx_x4_asym2_half_slave_rx_align.sv
// rtl/lpif_txrx_x4_asym2_half_slave_rx_align.sv - marker hunt/lock FSM and half-rate upstream unpack for the asym2 slave
module lpif_txrx_x4_asym2_half_slave_rx_align
  import lpif_asym2_pkg::*;
#(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic clk_wr,
  input  logic rst_wr,
  lpif_txrx_x4_asym2_half_slave_rx_align_if.slave bus
);
  localparam logic [7:0] LOCK_N   = 8'(LOCK_CNT);
  localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_CNT);

  logic [WORD_W-1:0] curr_lo, curr_hi, prev_upper;
  logic              w0_good, w1_good, sel_good;
  align_state_e      state;
  logic              phase, locked;
  logic [7:0]        cnt, errrun;
  logic [15:0]       err_cnt;
  logic              unused_rsvd;

  logic [PLD_W-1:0] pld       [2];
  logic [3:0]       f_state   [2];
  logic [1:0]       f_protid  [2];
  logic [63:0]      f_data    [2];
  logic             f_dvalid  [2];
  logic [3:0]       f_crc     [2];
  logic             f_crc_vld [2];
  logic             f_valid   [2];

  assign curr_lo = bus.rx_phy0[WORD_W-1:0];
  assign curr_hi = bus.rx_phy0[2*WORD_W-1:WORD_W];
  assign w0_good = window_good(curr_lo, curr_hi);
  assign w1_good = window_good(prev_upper, curr_lo);
  assign sel_good = phase ? w1_good : w0_good;
  assign unused_rsvd = curr_lo[WORD_W-2] ^ prev_upper[WORD_W-2];

  // Phase 1 straddles the cycle boundary: beat0 comes from last cycle's upper word.
  assign pld[0] = phase ? prev_upper[PLD_LSB +: PLD_W] : curr_lo[PLD_LSB +: PLD_W];
  assign pld[1] = phase ? curr_lo[PLD_LSB +: PLD_W]    : curr_hi[PLD_LSB +: PLD_W];

  for (genvar i = 0; i < 2; i++) begin : g_unpack
    lpif_asym2_payload_unpack u_unpack (
      .payload   (pld[i]),
      .state     (f_state[i]),
      .protid    (f_protid[i]),
      .data      (f_data[i]),
      .dvalid    (f_dvalid[i]),
      .crc       (f_crc[i]),
      .crc_valid (f_crc_vld[i]),
      .valid     (f_valid[i])
    );
  end

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state      <= OFFLINE;
      phase      <= 1'b0;
      locked     <= 1'b0;
      cnt        <= '0;
      errrun     <= '0;
      err_cnt    <= '0;
      prev_upper <= '0;
      bus.ustrm_state     <= '0;
      bus.ustrm_protid    <= '0;
      bus.ustrm_data      <= '0;
      bus.ustrm_dvalid    <= '0;
      bus.ustrm_crc       <= '0;
      bus.ustrm_crc_valid <= '0;
      bus.ustrm_valid     <= '0;
    end else begin
      prev_upper <= curr_hi;
      bus.ustrm_state     <= '0;
      bus.ustrm_protid    <= '0;
      bus.ustrm_data      <= '0;
      bus.ustrm_dvalid    <= '0;
      bus.ustrm_crc       <= '0;
      bus.ustrm_crc_valid <= '0;
      bus.ustrm_valid     <= '0;
      if (!bus.rx_online) begin
        state  <= OFFLINE;
        locked <= 1'b0;
        cnt    <= '0;
        errrun <= '0;
      end else begin
        case (state)
          OFFLINE: state <= HUNT;
          HUNT: begin
            if (w0_good || w1_good) begin
              phase <= !w0_good;
              cnt   <= 8'd1;
              state <= CHECK;
            end
          end
          CHECK: begin
            if (sel_good) begin
              cnt <= cnt + 8'd1;
              if (cnt + 8'd1 == LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              cnt   <= '0;
              state <= HUNT;
            end
          end
          LOCKED: begin
            bus.ustrm_state     <= {f_state[1], f_state[0]};
            bus.ustrm_protid    <= {f_protid[1], f_protid[0]};
            bus.ustrm_data      <= {f_data[1], f_data[0]};
            bus.ustrm_dvalid    <= {f_dvalid[1], f_dvalid[0]};
            bus.ustrm_crc       <= {f_crc[1], f_crc[0]};
            bus.ustrm_crc_valid <= {f_crc_vld[1], f_crc_vld[0]};
            if (sel_good) begin
              bus.ustrm_valid <= {f_valid[1], f_valid[0]};
              errrun          <= '0;
            end else begin
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
              if (errrun + 8'd1 == UNLOCK_N) begin
                errrun <= '0;
                state  <= HUNT;
                locked <= 1'b0;
              end else begin
                errrun <= errrun + 8'd1;
              end
            end
          end
          default: state <= OFFLINE;
        endcase
      end
    end
  end

  assign bus.rx_align_locked          = locked;
  assign bus.rx_align_phase           = phase;
  assign bus.rx_align_err_cnt         = err_cnt;
  assign bus.rx_upstream_debug_status = {state, phase, locked, 12'h000, err_cnt};
endmodule

// File: tb/tb_lpif_txrx_x4_asym2_half_slave_rx_align.sv
// tb/tb_lpif_txrx_x4_asym2_half_slave_rx_align.sv - directed bench for the asym2 slave rx aligner
module tb_lpif_txrx_x4_asym2_half_slave_rx_align;
  logic clk_wr = 1'b0;
  logic rst_wr = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_wr = ~clk_wr;

  lpif_txrx_x4_asym2_half_slave_rx_align_if bus ();
  lpif_txrx_x4_asym2_half_slave_rx_align_if sat_bus ();

  assign sat_bus.rx_online = bus.rx_online;
  assign sat_bus.rx_phy0   = bus.rx_phy0;

  lpif_txrx_x4_asym2_half_slave_rx_align #(.LOCK_CNT(8), .UNLOCK_CNT(4)) dut (
    .clk_wr (clk_wr),
    .rst_wr (rst_wr),
    .bus    (bus.slave)
  );

  // Second instance tolerates long error runs so err_cnt can be driven to saturation while locked.
  lpif_txrx_x4_asym2_half_slave_rx_align #(.LOCK_CNT(8), .UNLOCK_CNT(255)) dut_sat (
    .clk_wr (clk_wr),
    .rst_wr (rst_wr),
    .bus    (sat_bus.slave)
  );

  function automatic logic [76:0] mk_pld(input logic [3:0] st, input logic [1:0] pid,
                                         input logic [63:0] d, input logic dv,
                                         input logic [3:0] c, input logic cv, input logic v);
    return {v, cv, c, dv, d, pid, st};
  endfunction

  function automatic logic [79:0] mk_word(input logic mrk, input logic stb, input logic [76:0] p);
    return {mrk, 1'b0, p, stb};
  endfunction

  logic [76:0]  p0, p1, p1n, pa, pb;
  logic [159:0] good0, bad0, v1, bad1;

  task automatic step();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic test_reset();
    bus.rx_online = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rx_phy0 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end
    n_tests++; if (bus.ustrm_data !== 128'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", bus.ustrm_data); end
    n_tests++; if (bus.ustrm_valid !== 2'b00) begin n_fail++; $display("FAIL rst_valid: got %b want 00", bus.ustrm_valid); end
    n_tests++; if ({bus.ustrm_state, bus.ustrm_protid, bus.ustrm_crc, bus.ustrm_dvalid, bus.ustrm_crc_valid} !== 24'h0) begin
      n_fail++; $display("FAIL rst_fields: got %h want 0", {bus.ustrm_state, bus.ustrm_protid, bus.ustrm_crc, bus.ustrm_dvalid, bus.ustrm_crc_valid}); end
    n_tests++; if ({bus.rx_align_locked, bus.rx_align_phase, bus.rx_align_err_cnt} !== 18'h0) begin
      n_fail++; $display("FAIL rst_status: got %h want 0", {bus.rx_align_locked, bus.rx_align_phase, bus.rx_align_err_cnt}); end
    n_tests++; if (bus.rx_upstream_debug_status !== 32'h0) begin n_fail++; $display("FAIL rst_debug: got %h want 00000000", bus.rx_upstream_debug_status); end
    rst_wr = 1'b0;
    bus.rx_phy0 = bad0;
    step();
    n_tests++; if (bus.rx_upstream_debug_status !== 32'h0) begin n_fail++; $display("FAIL offline_idle: got %h want 00000000", bus.rx_upstream_debug_status); end
  endtask

  task automatic test_phase0_lock();
    bus.rx_online = 1'b1;
    bus.rx_phy0   = good0;
    step();
    n_tests++; if (bus.rx_upstream_debug_status[31:30] !== 2'b01) begin n_fail++; $display("FAIL p0_hunt: got %b want 01", bus.rx_upstream_debug_status[31:30]); end
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) begin
        n_tests++; if (bus.rx_align_locked !== 1'b0) begin n_fail++; $display("FAIL p0_early_lock: got %b want 0", bus.rx_align_locked); end
      end
    end
    n_tests++; if (bus.rx_upstream_debug_status !== 32'hD000_0000) begin n_fail++; $display("FAIL p0_locked_dbg: got %h want d0000000", bus.rx_upstream_debug_status); end
    n_tests++; if (bus.ustrm_valid !== 2'b00) begin n_fail++; $display("FAIL p0_no_fwd_in_check: got %b want 00", bus.ustrm_valid); end
    step();
    n_tests++; if (bus.ustrm_data !== 128'h5A5A_0000_0000_0002_A5A5_0000_0000_0001) begin n_fail++; $display("FAIL p0_data: got %h want 5a5a000000000002a5a5000000000001", bus.ustrm_data); end
    n_tests++; if (bus.ustrm_valid !== 2'b11) begin n_fail++; $display("FAIL p0_valid: got %b want 11", bus.ustrm_valid); end
    n_tests++; if ({bus.ustrm_state, bus.ustrm_protid, bus.ustrm_dvalid, bus.ustrm_crc, bus.ustrm_crc_valid} !== {8'hC3, 4'h9, 2'b01, 8'h5A, 2'b01}) begin
      n_fail++; $display("FAIL p0_fields: got %h want %h", {bus.ustrm_state, bus.ustrm_protid, bus.ustrm_dvalid, bus.ustrm_crc, bus.ustrm_crc_valid}, {8'hC3, 4'h9, 2'b01, 8'h5A, 2'b01}); end
    bus.rx_phy0 = {mk_word(1'b0, 1'b1, p1n), mk_word(1'b1, 1'b1, p0)};
    step();
    n_tests++; if (bus.ustrm_valid !== 2'b01) begin n_fail++; $display("FAIL p0_beat1_invalid: got %b want 01", bus.ustrm_valid); end
    n_tests++; if (bus.ustrm_protid !== 4'hD) begin n_fail++; $display("FAIL p0_protid2: got %h want d", bus.ustrm_protid); end
  endtask

  task automatic test_error_injection();
    bus.rx_phy0 = bad0;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_tests++; if ({bus.rx_align_locked, bus.ustrm_valid} !== 3'b100) begin n_fail++; $display("FAIL err_bad%0d: got locked/valid %b want 100", i, {bus.rx_align_locked, bus.ustrm_valid}); end
    end
    n_tests++; if (bus.rx_align_err_cnt !== 16'd3) begin n_fail++; $display("FAIL err_cnt3: got %0d want 3", bus.rx_align_err_cnt); end
    n_tests++; if (bus.ustrm_data !== 128'h5A5A_0000_0000_0002_A5A5_0000_0000_0001) begin n_fail++; $display("FAIL err_fields_kept: got %h", bus.ustrm_data); end
    bus.rx_phy0 = good0;
    step();
    n_tests++; if (bus.ustrm_valid !== 2'b11) begin n_fail++; $display("FAIL err_recover_valid: got %b want 11", bus.ustrm_valid); end
    bus.rx_phy0 = bad0;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 3) begin
        n_tests++; if (bus.rx_align_locked !== 1'b1) begin n_fail++; $display("FAIL err_still_locked: got %b want 1", bus.rx_align_locked); end
      end
    end
    n_tests++; if (bus.rx_upstream_debug_status !== 32'h4000_0007) begin n_fail++; $display("FAIL err_unlock_dbg: got %h want 40000007", bus.rx_upstream_debug_status); end
    n_tests++; if (sat_bus.rx_upstream_debug_status !== 32'hD000_0007) begin n_fail++; $display("FAIL sat_still_locked: got %h want d0000007", sat_bus.rx_upstream_debug_status); end
  endtask

  task automatic test_check_abort();
    bus.rx_phy0 = good0;
    for (int i = 0; i < 5; i++) step();
    n_tests++; if (bus.rx_upstream_debug_status[31:28] !== 4'b1000) begin n_fail++; $display("FAIL abort_check: got %b want 1000", bus.rx_upstream_debug_status[31:28]); end
    bus.rx_phy0 = bad0;
    step();
    n_tests++; if (bus.rx_upstream_debug_status[31:28] !== 4'b0100) begin n_fail++; $display("FAIL abort_hunt: got %b want 0100", bus.rx_upstream_debug_status[31:28]); end
    bus.rx_phy0 = good0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) begin
        n_tests++; if (bus.rx_align_locked !== 1'b0) begin n_fail++; $display("FAIL abort_early_lock: got %b want 0", bus.rx_align_locked); end
      end
    end
    n_tests++; if (bus.rx_align_locked !== 1'b1) begin n_fail++; $display("FAIL abort_relock: got %b want 1", bus.rx_align_locked); end
  endtask

  task automatic test_online_drop();
    bus.rx_online = 1'b0;
    bus.rx_phy0   = good0;
    step();
    n_tests++; if (bus.rx_upstream_debug_status !== 32'h0000_0007) begin n_fail++; $display("FAIL drop_dbg: got %h want 00000007", bus.rx_upstream_debug_status); end
    n_tests++; if ({bus.ustrm_data, bus.ustrm_valid, bus.ustrm_state} !== 138'h0) begin n_fail++; $display("FAIL drop_ustrm: got %h want 0", {bus.ustrm_data, bus.ustrm_valid, bus.ustrm_state}); end
    n_tests++; if (sat_bus.rx_upstream_debug_status !== 32'h0000_0008) begin n_fail++; $display("FAIL drop_sat_dbg: got %h want 00000008", sat_bus.rx_upstream_debug_status); end
  endtask

  task automatic test_phase1_lock();
    bus.rx_online = 1'b1;
    bus.rx_phy0   = v1;
    step();
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) begin
        n_tests++; if (bus.rx_align_locked !== 1'b0) begin n_fail++; $display("FAIL p1_early_lock: got %b want 0", bus.rx_align_locked); end
      end
    end
    n_tests++; if (bus.rx_upstream_debug_status !== 32'hF000_0007) begin n_fail++; $display("FAIL p1_locked_dbg: got %h want f0000007", bus.rx_upstream_debug_status); end
    bus.rx_phy0 = {mk_word(1'b1, 1'b1, pa), mk_word(1'b0, 1'b1, p1)};
    step();
    bus.rx_phy0 = {mk_word(1'b1, 1'b1, p0), mk_word(1'b0, 1'b1, pb)};
    step();
    n_tests++; if (bus.ustrm_data !== 128'h5555_6666_7777_8888_1111_2222_3333_4444) begin n_fail++; $display("FAIL p1_data: got %h want 55556666777788881111222233334444", bus.ustrm_data); end
    n_tests++; if ({bus.ustrm_state, bus.ustrm_valid} !== {8'h21, 2'b11}) begin n_fail++; $display("FAIL p1_state_valid: got %h want %h", {bus.ustrm_state, bus.ustrm_valid}, {8'h21, 2'b11}); end
  endtask

  task automatic test_err_saturate();
    for (int c = 0; c < 258; c++) begin
      bus.rx_phy0 = bad1;
      for (int i = 0; i < 254; i++) step();
      if (c == 0) begin
        n_tests++; if (sat_bus.rx_align_err_cnt !== 16'd262) begin n_fail++; $display("FAIL sat_first_run: got %0d want 262", sat_bus.rx_align_err_cnt); end
      end
      bus.rx_phy0 = v1;
      step();
    end
    n_tests++; if (sat_bus.rx_align_err_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_err_cnt: got %h want ffff", sat_bus.rx_align_err_cnt); end
    n_tests++; if (sat_bus.rx_align_locked !== 1'b1) begin n_fail++; $display("FAIL sat_locked: got %b want 1", sat_bus.rx_align_locked); end
    n_tests++; if ({bus.rx_align_locked, bus.rx_align_err_cnt} !== {1'b0, 16'd11}) begin n_fail++; $display("FAIL main_after_sat: got %h want %h", {bus.rx_align_locked, bus.rx_align_err_cnt}, {1'b0, 16'd11}); end
  endtask

  initial begin
    p0    = mk_pld(4'h3, 2'h1, 64'hA5A5_0000_0000_0001, 1'b1, 4'hA, 1'b1, 1'b1);
    p1    = mk_pld(4'hC, 2'h2, 64'h5A5A_0000_0000_0002, 1'b0, 4'h5, 1'b0, 1'b1);
    p1n   = mk_pld(4'h0, 2'h3, 64'h0000_0000_0000_1234, 1'b1, 4'hF, 1'b1, 1'b0);
    pa    = mk_pld(4'h1, 2'h0, 64'h1111_2222_3333_4444, 1'b1, 4'h1, 1'b1, 1'b1);
    pb    = mk_pld(4'h2, 2'h3, 64'h5555_6666_7777_8888, 1'b0, 4'h2, 1'b0, 1'b1);
    good0 = {mk_word(1'b0, 1'b1, p1), mk_word(1'b1, 1'b1, p0)};
    bad0  = {mk_word(1'b0, 1'b1, p1), mk_word(1'b0, 1'b1, p0)};
    v1    = {mk_word(1'b1, 1'b1, p0), mk_word(1'b0, 1'b1, p1)};
    bad1  = {mk_word(1'b1, 1'b1, p0), mk_word(1'b1, 1'b1, p1)};
    bus.rx_online = 1'b0;
    bus.rx_phy0   = '0;
    test_reset();
    test_phase0_lock();
    test_error_injection();
    test_check_abort();
    test_online_drop();
    test_phase1_lock();
    test_err_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
